// File: rtl/cdec8_dbgmon.sv
// cdec8_dbgmon: UART debug monitor that reads CDEC8 resources on host command
module cdec8_dbgmon #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  DUMP_LAST    = 8'h0F
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] resad,
  input  logic [7:0] resdt,
  output logic       busy,
  output logic       rx_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {C_IDLE, C_LATCH, C_SAMPLE, C_SEND} cmd_state_t;
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_t     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          buf_valid_q, rx_err_q;
  logic [7:0]    buf_q;
  cmd_state_t    state_q;
  logic          dump_q, txd_q;
  logic [7:0]    addr_q, resad_q;
  logic [8:0]    tx_sh_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic          rx_tick, rx_done, rx_ferr, pop;
  assign rx_tick = rx_cnt_q == (rx_state_q == R_START ? HALF : FULL);
  assign rx_done = rx_state_q == R_STOP && rx_tick && rx_s2_q;
  assign rx_ferr = rx_state_q == R_STOP && rx_tick && !rx_s2_q;
  assign pop     = state_q == C_IDLE && buf_valid_q;
  assign txd     = txd_q;
  assign resad   = resad_q;
  assign busy    = state_q != C_IDLE;
  assign rx_err  = rx_err_q;
  // synchronize rxd and keep one extra stage for falling-edge detection
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rxd;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end
  // receive 8N1 frames, sampling each bit at its mid-point
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_cnt_q <= rx_tick ? '0 : rx_cnt_q + 1'b1;
      case (rx_state_q)
        R_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_s2_q && rx_s3_q) rx_state_q <= R_START;
        end
        R_START: if (rx_tick) begin
          rx_state_q <= rx_s2_q ? R_IDLE : R_DATA;
          rx_bit_q   <= '0;
        end
        R_DATA: if (rx_tick) begin
          rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_q <= R_STOP;
        end
        default: if (rx_tick) rx_state_q <= R_IDLE;
      endcase
    end
  end
  // one-byte pending buffer; a same-cycle pop frees the slot for the new byte
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
      rx_err_q    <= 1'b0;
    end else begin
      rx_err_q <= rx_ferr || (rx_done && buf_valid_q && !pop);
      if (rx_done && (!buf_valid_q || pop)) begin
        buf_q       <= rx_sh_q;
        buf_valid_q <= 1'b1;
      end else if (pop) begin
        buf_valid_q <= 1'b0;
      end
    end
  end
  // command FSM: latch address, sample resource, transmit, repeat for dumps
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q  <= C_IDLE;
      dump_q   <= 1'b0;
      addr_q   <= '0;
      resad_q  <= '0;
      txd_q    <= 1'b1;
      tx_sh_q  <= '1;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
    end else begin
      case (state_q)
        C_IDLE: if (buf_valid_q) begin
          dump_q  <= buf_q == 8'hFF;
          addr_q  <= buf_q == 8'hFF ? 8'h00 : buf_q;
          state_q <= C_LATCH;
        end
        C_LATCH: begin
          resad_q <= addr_q;
          state_q <= C_SAMPLE;
        end
        C_SAMPLE: begin
          tx_sh_q  <= {1'b1, resdt};
          txd_q    <= 1'b0;
          tx_cnt_q <= '0;
          tx_bit_q <= '0;
          state_q  <= C_SEND;
        end
        default: begin
          tx_cnt_q <= tx_cnt_q == FULL ? '0 : tx_cnt_q + 1'b1;
          if (tx_cnt_q == FULL) begin
            if (tx_bit_q == 4'd9) begin
              if (dump_q && addr_q < DUMP_LAST) begin
                addr_q  <= addr_q + 8'd1;
                state_q <= C_LATCH;
              end else begin
                dump_q  <= 1'b0;
                state_q <= C_IDLE;
              end
            end else begin
              txd_q    <= tx_sh_q[0];
              tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
              tx_bit_q <= tx_bit_q + 4'd1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: doc/cdec8_dbgmon.md
# cdec8_dbgmon

UART debug monitor for the CDEC8 processor on DE0. It consumes the data path's resource observation bus. It receives resource-address commands from the host PC over a serial line, drives `resad`, samples the returned `resdt` byte and transmits it back. A dump command streams resources 0x00–0x0F in one burst. The block lives beside the data path and control unit at the board top level; the top level muxes `state`/`signal` onto `resdt` at 0x0B/0x0C.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4.
- `DUMP_LAST`, 8'h0F, last address streamed by the dump command.

- `clock`  in  1  system clock, rising edge.
- `reset_N`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  UART receive line from host, asynchronous, idle high.
- `txd`  out  1  UART transmit line to host, idle high.
- `resad`  out  8  resource address to data path observation bus.
- `resdt`  in  8  resource data returned for `resad`; combinational from registers.
- `busy`  out  1  high while a command is latched, sampling or transmitting.
- `rx_err`  out  1  one-cycle pulse on framing error or overrun.

## Operation
- Frame format is 8N1, LSB first.
- **RX path:**
  - `rxd` passes through a 2-flop synchronizer.
  - A falling edge in RX idle starts a frame.
  - The start bit is re-checked at CLKS_PER_BIT/2; if high, the frame is a glitch and RX returns to idle silently.
  - Data bits are sampled every CLKS_PER_BIT from the start mid-point.
  - The stop bit is sampled at its mid-point. If low, pulse `rx_err` and discard the byte. If high, the byte goes to the pending buffer.
- **Pending buffer:** one byte deep with a valid flag.
  - A new byte arriving while the buffer is valid is dropped, `rx_err` pulses, and the old byte is kept.
- **Command FSM:** IDLE → LATCH → SAMPLE → SEND → (IDLE | LATCH).
  - **IDLE:** if the buffer is valid, pop it.
    - Byte 8'hFF: set dump mode, load address 8'h00.
    - Any other byte: load that byte as address, single mode.
    - Go to LATCH.
  - **LATCH:** `resad` ← address; one settle cycle; go to SAMPLE.
  - **SAMPLE:** capture `resdt` into the TX shift register; go to SEND.
  - **SEND:** transmit 10 bits (start 0, data LSB first, stop 1), each CLKS_PER_BIT cycles.
    - At the end of the stop bit, in dump mode with address < DUMP_LAST: address+1, go to LATCH.
    - Otherwise clear dump mode and go to IDLE.
- Address arithmetic is 8-bit. A dump never wraps; it ends at DUMP_LAST.
- `resad` holds its last value in IDLE; it is not returned to 0.
- `busy` = (state != IDLE).
- Reception continues during SEND. A command received during a dump is held in the buffer and executed after the dump completes.

## Timing
- **Reset values:**
  - `txd`=1, `resad`=8'h00, `busy`=0, `rx_err`=0.
  - FSM in IDLE, buffer empty, RX idle, dump mode cleared.
- Reset asserted mid-frame or mid-dump aborts immediately to these values. An RX frame in progress is lost.
- **Single-command latency:**
  - Stop-bit mid-sample at cycle N → buffer valid N+1 → IDLE pops N+1, LATCH N+2 (`resad` valid from N+3) → SAMPLE N+3 → `txd` start bit begins N+4.
  - The full response occupies 10·CLKS_PER_BIT cycles.
- **Dump:** consecutive bytes are separated by exactly 2 cycles of `txd`=1 beyond the stop bit (LATCH, SAMPLE). Total length is 16·(10·CLKS_PER_BIT+2) cycles for the default DUMP_LAST.
- `resdt` is sampled exactly one cycle after `resad` changes. The source must settle within one cycle.
- A buffer pop and a new stop-bit completion in the same cycle: the pop takes priority and the new byte fills the freed buffer, with no overrun.
- `rx_err` is exactly one cycle wide per event.

## Test plan
All scenarios use CLKS_PER_BIT=4 and a bench model of the data path observation bus.

- **Single read:** send 8'h08 with A=8'h5A → `resad`=8'h08 before sampling; `txd` frame carries 8'h5A; `busy` falls after the stop bit.
- **Dump:** send 8'hFF with `resdt`=address^8'hA0 → 16 frames 8'hA0…8'hAF with 2-cycle gaps; `resad` ends at 8'h0F.
- **Framing error:** send 8'h03 with the stop bit forced low → one `rx_err` pulse; no TX; `busy` stays 0; next valid 8'h03 answers normally.
- **Overrun:** during a dump, send 8'h01 then 8'h02 → one `rx_err` pulse; after the dump ends, exactly one response for 8'h01; 8'h02 is discarded.
- **Glitch:** drive `rxd` low for 1 cycle → no `rx_err`, no response.
- **Reset mid-dump:** assert `reset_N` low during the 5th frame → `txd`=1, `resad`=8'h00, `busy`=0 at once; after release, 8'h00 reads PC correctly.
